// File: rtl/shot_pkg.sv
// shot_pkg: launcher state/direction types and default tuning constants
package shot_pkg;
  typedef enum logic [1:0] {IDLE, FIRE, FLIGHT, COOLDOWN} launcher_state_t;
  typedef enum logic [2:0] {UP = 3'd0, UPLEFT = 3'd1, UPRIGHT = 3'd2, LEFT = 3'd3, RIGHT = 3'd4} shot_dir_t;
  localparam int DEF_MAX_AMMO = 5;
  localparam int DEF_COOLDOWN_FRAMES = 8;
  localparam int DEF_REFILL_FRAMES = 60;
  localparam int DEF_FLIGHT_TIMEOUT_FRAMES = 120;
  localparam int DEF_OFFSCREEN_Y = 640;
endpackage

// File: rtl/shot_frame_timer.sv
// shot_frame_timer: 8-bit startOfFrame counter that stops at its terminal count
module shot_frame_timer (
  input  logic       clk,
  input  logic       resetN,
  input  logic       sof,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] terminal,
  output logic       done
);
  logic [7:0] count;
  assign done = count == terminal;
  // count frames while enabled, never past the terminal value
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) count <= '0;
    else if (clear) count <= '0;
    else if (enable && sof && !done) count <= count + 8'd1;
endmodule

// File: rtl/shot_launcher.sv
// shot_launcher: fire/flight/cooldown control with ammo refill; SHOT_LAUNCHER_AUTOFIRE_EN enables hold-to-repeat
module shot_launcher
  import shot_pkg::*;
#(
  parameter int MAX_AMMO = DEF_MAX_AMMO,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter int REFILL_FRAMES = DEF_REFILL_FRAMES,
  parameter int FLIGHT_TIMEOUT_FRAMES = DEF_FLIGHT_TIMEOUT_FRAMES,
  parameter int OFFSCREEN_Y = DEF_OFFSCREEN_Y
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               fireKey,
  input  logic [2:0]         dirKeys,
  input  logic               shotHit,
  input  logic signed [10:0] shotTopLeftY,
  output logic               triggerShot,
  output logic [2:0]         shotDirection,
  output logic [3:0]         ammo,
  output logic               ready
);
  localparam logic signed [10:0] OFF_Y = 11'(OFFSCREEN_Y);
  localparam logic [3:0] FULL = 4'(MAX_AMMO);
  launcher_state_t state, state_next;
  logic key_q, key_qq, armed, fire_req, y_armed, leave_flight;
  logic cool_done, flight_done, refill_done, refill_inc, fire_dec;
  // armed stays low after reset until the key has been seen released
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      key_q <= 1'b0;
      key_qq <= 1'b0;
      armed <= 1'b0;
    end else begin
      key_q <= fireKey;
      key_qq <= key_q;
      armed <= armed | ~fireKey;
    end
`ifdef SHOT_LAUNCHER_AUTOFIRE_EN
  assign fire_req = key_q & armed;
`else
  assign fire_req = key_q & ~key_qq & armed;
`endif
  // the mover only updates Y on a later frame, so Y is trusted after the first frame of flight
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) y_armed <= 1'b0;
    else y_armed <= state == FLIGHT && (y_armed || startOfFrame);
  assign leave_flight = shotHit || (y_armed && shotTopLeftY >= OFF_Y) || flight_done;
  assign fire_dec = state == FIRE;
  assign refill_inc = refill_done && ammo != FULL;
  assign ready = state == IDLE && ammo != 4'd0;
  // next-state and one-clk trigger pulse
  always_comb begin
    state_next = state;
    triggerShot = 1'b0;
    case (state)
      IDLE:     if (fire_req && ammo != 4'd0) state_next = FIRE;
      FIRE:     begin
        state_next = FLIGHT;
        triggerShot = 1'b1;
      end
      FLIGHT:   if (leave_flight) state_next = COOLDOWN;
      COOLDOWN: if (cool_done) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end
  // state, ammo bookkeeping and direction capture on entry to FIRE
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state <= IDLE;
      ammo <= FULL;
      shotDirection <= '0;
    end else begin
      state <= state_next;
      ammo <= ammo + {3'b0, refill_inc} - {3'b0, fire_dec};
      if (state == IDLE && state_next == FIRE) shotDirection <= dirKeys;
    end
  shot_frame_timer u_cool (
    .clk(clk), .resetN(resetN), .sof(startOfFrame),
    .clear(state != COOLDOWN), .enable(state == COOLDOWN),
    .terminal(8'(COOLDOWN_FRAMES)), .done(cool_done)
  );
  shot_frame_timer u_flight (
    .clk(clk), .resetN(resetN), .sof(startOfFrame),
    .clear(state != FLIGHT), .enable(state == FLIGHT),
    .terminal(8'(FLIGHT_TIMEOUT_FRAMES)), .done(flight_done)
  );
  shot_frame_timer u_refill (
    .clk(clk), .resetN(resetN), .sof(startOfFrame),
    .clear(ammo == FULL || refill_done), .enable(ammo != FULL),
    .terminal(8'(REFILL_FRAMES)), .done(refill_done)
  );
endmodule

// File: tb/tb_shot_launcher.sv
// tb_shot_launcher: directed checks of firing, flight exit, cooldown, refill and reset abort
module tb_shot_launcher;
  import shot_pkg::*;
  logic clk, resetN, startOfFrame, fireKey, shotHit, triggerShot, ready;
  logic [2:0] dirKeys, shotDirection;
  logic [3:0] ammo;
  logic signed [10:0] shotTopLeftY;
  int checks = 0, errors = 0, shots = 0, s0;

  shot_launcher dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fireKey(fireKey),
    .dirKeys(dirKeys), .shotHit(shotHit), .shotTopLeftY(shotTopLeftY),
    .triggerShot(triggerShot), .shotDirection(shotDirection), .ammo(ammo), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  // count clocks with the trigger pulse high
  always @(negedge clk) if (triggerShot) shots <= shots + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic h = 1'b0);
    startOfFrame = 1'b1;
    shotHit = h;
    tick(1);
    startOfFrame = 1'b0;
    shotHit = 1'b0;
    tick(3);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    fireKey = 1'b0;
    tick(2);
    resetN = 1'b1;
    tick(2);
  endtask

  initial begin
    startOfFrame = 1'b0; fireKey = 1'b0; shotHit = 1'b0; dirKeys = 3'd0; shotTopLeftY = 11'sd0;
    do_reset();
    check("rst_ammo", ammo, 5);
    check("rst_dir", shotDirection, 0);
    check("rst_trig", triggerShot, 0);
    check("rst_ready", ready, 1);
    check("rst_state", dut.state, IDLE);

    // single shot with direction UPRIGHT
    dirKeys = 3'd2; s0 = shots; fireKey = 1'b1;
    tick(4);
    check("fire_pulses", shots - s0, 1);
    check("fire_dir", shotDirection, 2);
    check("fire_ammo", ammo, 4);
    check("fire_state", dut.state, FLIGHT);
    fireKey = 1'b0;

    // hit ten frames in, ready after exactly eight cooldown frames
    repeat (10) frame();
    check("flight10_state", dut.state, FLIGHT);
    shotHit = 1'b1; tick(1); shotHit = 1'b0;
    check("hit_state", dut.state, COOLDOWN);
    repeat (7) frame();
    check("cool7_ready", ready, 0);
    frame();
    check("cool8_ready", ready, 1);

    // drain the magazine, empty-key ignored, refill at frame 60
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fireKey = 1'b1; tick(3);
      shotHit = 1'b1; tick(1); shotHit = 1'b0; fireKey = 1'b0;
      repeat (8) frame();
      check("drain_ammo", ammo, 4 - i);
    end
    check("empty_ready", ready, 0);
    s0 = shots; fireKey = 1'b1; tick(4); fireKey = 1'b0; tick(2);
    check("empty_nofire", shots - s0, 0);
    repeat (19) frame();
    check("refill59_ammo", ammo, 0);
    frame();
    check("refill60_ammo", ammo, 1);
    check("refill60_ready", ready, 1);
    tick(4);
    check("empty_not_queued", shots - s0, 0);

    // off-screen Y ends flight on the 2nd frame, in-screen Y times out at 120
    do_reset();
    shotTopLeftY = 11'sd781; fireKey = 1'b1; tick(3); fireKey = 1'b0;
    tick(2);
    check("y_first_frame", dut.state, FLIGHT);
    frame();
    check("y_second_frame", dut.state, COOLDOWN);
    repeat (8) frame();
    check("y_back_idle", dut.state, IDLE);
    shotTopLeftY = 11'sd100; fireKey = 1'b1; tick(3); fireKey = 1'b0;
    repeat (119) frame();
    check("to_119", dut.state, FLIGHT);
    frame();
    check("to_120", dut.state, COOLDOWN);

    // held key for 100 frames with hits
    do_reset();
    s0 = shots; fireKey = 1'b1;
    repeat (100) frame(1'b1);
`ifdef SHOT_LAUNCHER_AUTOFIRE_EN
    check("hold_repeat", (shots - s0) > 1, 1);
`else
    check("hold_once", shots - s0, 1);
    check("hold_ammo", ammo, 5);
`endif
    fireKey = 1'b0;

    // reset mid-cooldown with key held
    do_reset();
    fireKey = 1'b1; tick(3);
    shotHit = 1'b1; tick(1); shotHit = 1'b0;
    frame(); frame();
    check("pre_abort_state", dut.state, COOLDOWN);
    resetN = 1'b0; #1;
    check("abort_state", dut.state, IDLE);
    check("abort_ammo", ammo, 5);
    tick(2); resetN = 1'b1; s0 = shots;
    repeat (5) frame();
    check("abort_held_nofire", shots - s0, 0);
    check("abort_idle", dut.state, IDLE);
    fireKey = 1'b0; tick(2);
    dirKeys = 3'd4; fireKey = 1'b1; tick(4);
    check("rearm_fire", shots - s0, 1);
    check("rearm_dir", shotDirection, 4);
    dirKeys = 3'd1; tick(3);
    check("dir_hold", shotDirection, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
